// File: rtl/dma_priority_arbiter.sv
// DMA request arbiter and bus-hold sequencer.
// Qualifies DREQ/SwReq against the mask and picks a channel with fixed or
// rotating priority. It runs the HRQ/HLDA handshake with the CPU and drives
// DACK to the granted channel.
module dma_priority_arbiter #(
   parameter  int NCH      = 4,
   parameter  int REQ_SYNC = 1,
   localparam int CW       = $clog2(NCH)
) (
   input  logic           Clock,
   input  logic           Reset,
   input  logic [NCH-1:0] DREQ,
   input  logic [7:0]     CommandReg,
   input  logic [NCH-1:0] MaskReg,
   input  logic [NCH-1:0] SwReq,
   input  logic           HLDA,
   input  logic           ServiceDone,
   output logic           HRQ,
   output logic [NCH-1:0] DACK,
   output logic           GrantValid,
   output logic [CW-1:0]  GrantChan,
   output logic [NCH-1:0] PendingReq,
   output logic [NCH-1:0] SwReqClr
);

   typedef enum logic [1:0] {IDLE, REQ, GRANT} state_t;

   state_t                       state_q, state_d;
   logic                         hrq_q, hrq_d;
   logic                         gv_q, gv_d;
   logic [CW-1:0]                chan_q, chan_d;
   logic [CW-1:0]                lp_q, lp_d;
   logic [NCH-1:0]               pend_q, pend_d;
   logic [NCH-1:0]               clr_q, clr_d;
   logic [REQ_SYNC-1:0][NCH-1:0] sync_q, sync_d;

   logic [NCH-1:0] dreq_pol;
   logic [NCH-1:0] pend;
   logic [CW-1:0]  winner;
   logic [CW-1:0]  base;
   logic [CW-1:0]  idx;
   logic           found;
   logic           unused_cmd;

   // Bits of the command register owned by other blocks.
   assign unused_cmd = ^{CommandReg[5], CommandReg[3], CommandReg[1:0]};

   // Normalise DREQ polarity so that 1 always means "requesting".
   assign dreq_pol = DREQ ^ {NCH{CommandReg[6]}};

   // Sampling chain: one or two flops between the pins and the arbiter.
   if (REQ_SYNC > 1) begin : g_sync2
      always_comb begin
         sync_d = {sync_q[0], dreq_pol};
      end
   end else begin : g_sync1
      always_comb begin
         sync_d = dreq_pol;
      end
   end

   // Software requests bypass both the sampling chain and the mask.
   always_comb begin
      pend   = (sync_q[REQ_SYNC-1] & ~MaskReg) | SwReq;
      pend_d = pend;
   end

   // Priority search starting just after the lowest-priority channel;
   // fixed mode behaves as if that pointer were parked at NCH-1.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      base   = CommandReg[4] ? lp_q : CW'(NCH - 1);
      for (int k = 1; k <= NCH; k++) begin
         idx = base + CW'(k);
         if (!found && pend[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   // Handshake sequencer: IDLE -> REQ (HRQ up) -> GRANT (HLDA seen) -> IDLE.
   always_comb begin
      state_d = state_q;
      hrq_d   = hrq_q;
      gv_d    = gv_q;
      chan_d  = chan_q;
      lp_d    = lp_q;
      clr_d   = '0;
      case (state_q)
         IDLE: begin
            if (|pend && !CommandReg[2]) begin
               state_d = REQ;
               hrq_d   = 1'b1;
            end
         end
         REQ: begin
            if (HLDA) begin
               state_d = GRANT;
               chan_d  = winner;
               gv_d    = 1'b1;
            end else if (pend == '0) begin
               state_d = IDLE;
               hrq_d   = 1'b0;
            end
         end
         GRANT: begin
            // ServiceDone wins over a simultaneous HLDA drop.
            if (ServiceDone) begin
               state_d       = IDLE;
               hrq_d         = 1'b0;
               gv_d          = 1'b0;
               clr_d[chan_q] = 1'b1;
               lp_d          = chan_q;
            end else if (!HLDA) begin
               state_d = IDLE;
               hrq_d   = 1'b0;
               gv_d    = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            hrq_d   = 1'b0;
            gv_d    = 1'b0;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= IDLE;
         hrq_q   <= 1'b0;
         gv_q    <= 1'b0;
         chan_q  <= '0;
         lp_q    <= CW'(NCH - 1);
         pend_q  <= '0;
         clr_q   <= '0;
         sync_q  <= '0;
      end else begin
         state_q <= state_d;
         hrq_q   <= hrq_d;
         gv_q    <= gv_d;
         chan_q  <= chan_d;
         lp_q    <= lp_d;
         pend_q  <= pend_d;
         clr_q   <= clr_d;
         sync_q  <= sync_d;
      end
   end

   // DACK decoded from registered grant state at the configured polarity.
   always_comb begin
      DACK = {NCH{~CommandReg[7]}};
      if (gv_q) DACK[chan_q] = CommandReg[7];
   end

   assign HRQ        = hrq_q;
   assign GrantValid = gv_q;
   assign GrantChan  = chan_q;
   assign PendingReq = pend_q;
   assign SwReqClr   = clr_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Bench for dma_priority_arbiter: directed scenarios plus a randomized run
// checked cycle by cycle against a behavioural model.
module tb_dma_priority_arbiter;
   localparam int NCH = 4;
   localparam int RS  = 2;

   logic           Clock = 1'b0;
   logic           Reset = 1'b1;
   logic [NCH-1:0] DREQ = '0;
   logic [7:0]     CommandReg = '0;
   logic [NCH-1:0] MaskReg = '0;
   logic [NCH-1:0] SwReq = '0;
   logic           HLDA = 1'b0;
   logic           ServiceDone = 1'b0;
   logic           HRQ;
   logic [NCH-1:0] DACK;
   logic           GrantValid;
   logic [1:0]     GrantChan;
   logic [NCH-1:0] PendingReq;
   logic [NCH-1:0] SwReqClr;

   int checks = 0;
   int errors = 0;

   dma_priority_arbiter #(.NCH(NCH), .REQ_SYNC(RS)) dut (
      .Clock(Clock), .Reset(Reset), .DREQ(DREQ), .CommandReg(CommandReg),
      .MaskReg(MaskReg), .SwReq(SwReq), .HLDA(HLDA), .ServiceDone(ServiceDone),
      .HRQ(HRQ), .DACK(DACK), .GrantValid(GrantValid), .GrantChan(GrantChan),
      .PendingReq(PendingReq), .SwReqClr(SwReqClr)
   );

   always #5 Clock = ~Clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- behavioural model ----------------
   // phase: 0 = bus not requested, 1 = waiting for HLDA, 2 = channel served
   logic [NCH-1:0] m_line [RS];
   logic [NCH-1:0] m_pend;
   logic [NCH-1:0] m_pendreg, m_clr;
   int             m_phase, m_chan, m_lp;

   assign m_pend = (m_line[RS-1] & ~MaskReg) | SwReq;

   function automatic int pick(logic [NCH-1:0] p, int lp, bit rot);
      int start = rot ? lp : NCH - 1;
      for (int k = 1; k <= NCH; k++)
         if (p[(start + k) % NCH]) return (start + k) % NCH;
      return 0;
   endfunction

   always @(posedge Clock) begin
      if (Reset) begin
         for (int i = 0; i < RS; i++) m_line[i] <= '0;
         m_phase <= 0; m_chan <= 0; m_lp <= NCH - 1;
         m_pendreg <= '0; m_clr <= '0;
      end else begin
         m_line[0] <= DREQ ^ {NCH{CommandReg[6]}};
         for (int i = 1; i < RS; i++) m_line[i] <= m_line[i-1];
         m_pendreg <= m_pend;
         m_clr <= '0;
         if (m_phase == 0 && m_pend != 0 && !CommandReg[2]) m_phase <= 1;
         else if (m_phase == 1 && HLDA) begin
            m_phase <= 2;
            m_chan  <= pick(m_pend, m_lp, CommandReg[4]);
         end
         else if (m_phase == 1 && m_pend == 0) m_phase <= 0;
         else if (m_phase == 2 && ServiceDone) begin
            m_phase <= 0;
            m_clr   <= 4'(1) << m_chan;
            m_lp    <= m_chan;
         end
         else if (m_phase == 2 && !HLDA) m_phase <= 0;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      Reset = 1'b1; DREQ = '0; MaskReg = '0; SwReq = '0; HLDA = 1'b0; ServiceDone = 1'b0;
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
   endtask

   task automatic wait_hrq(output bit ok);
      int n = 0;
      while (HRQ !== 1'b1 && n < 30) begin @(negedge Clock); n++; end
      ok = (HRQ === 1'b1);
   endtask

   // One full service: HLDA 3 cycles after HRQ, one grant cycle, ServiceDone.
   // Returns the granted channel, -1 if no grant appeared, -2 on HRQ timeout.
   task automatic serve(output int ch);
      bit ok;
      wait_hrq(ok);
      repeat (3) @(negedge Clock);
      HLDA = 1'b1;
      @(negedge Clock);
      ch = (GrantValid === 1'b1) ? int'(GrantChan) : -1;
      if (!ok) ch = -2;
      ServiceDone = 1'b1;
      @(negedge Clock);
      ServiceDone = 1'b0; HLDA = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      CommandReg = 8'h04;
      do_reset();
      Reset = 1'b1;
      @(negedge Clock);
      checks++; if (HRQ !== 1'b0 || GrantValid !== 1'b0 || GrantChan !== 2'd0) begin
         errors++; $display("FAIL reset_ctl: HRQ=%b GV=%b CH=%0d want 0 0 0", HRQ, GrantValid, GrantChan); end
      checks++; if (PendingReq !== 4'h0 || SwReqClr !== 4'h0) begin
         errors++; $display("FAIL reset_vec: PEND=%b CLR=%b want 0000 0000", PendingReq, SwReqClr); end
      checks++; if (DACK !== 4'hF) begin
         errors++; $display("FAIL reset_dack: got %b want 1111", DACK); end
      Reset = 1'b0;
      CommandReg = 8'h00;
   endtask

   task automatic test_basic();
      CommandReg = 8'h00;
      do_reset();
      DREQ = 4'b0100;
      repeat (RS) @(negedge Clock);
      checks++; if (HRQ !== 1'b0) begin
         errors++; $display("FAIL basic_hrq_early: got %b want 0", HRQ); end
      @(negedge Clock);
      checks++; if (HRQ !== 1'b1) begin
         errors++; $display("FAIL basic_hrq_latency: got %b want 1", HRQ); end
      repeat (3) @(negedge Clock);
      checks++; if (HRQ !== 1'b1 || GrantValid !== 1'b0) begin
         errors++; $display("FAIL basic_wait: HRQ=%b GV=%b want 1 0", HRQ, GrantValid); end
      HLDA = 1'b1;
      @(negedge Clock);
      checks++; if (GrantValid !== 1'b1 || GrantChan !== 2'd2) begin
         errors++; $display("FAIL basic_grant: GV=%b CH=%0d want 1 2", GrantValid, GrantChan); end
      checks++; if (DACK !== 4'b1011) begin
         errors++; $display("FAIL basic_dack: got %b want 1011", DACK); end
      DREQ = 4'b0011;                       // higher priority arrives mid-service
      repeat (4) @(negedge Clock);
      checks++; if (GrantChan !== 2'd2 || DACK !== 4'b1011) begin
         errors++; $display("FAIL basic_no_preempt: CH=%0d DACK=%b want 2 1011", GrantChan, DACK); end
      ServiceDone = 1'b1;
      @(negedge Clock);
      ServiceDone = 1'b0; HLDA = 1'b0; DREQ = '0;
      checks++; if (HRQ !== 1'b0 || GrantValid !== 1'b0 || DACK !== 4'hF) begin
         errors++; $display("FAIL basic_done: HRQ=%b GV=%b DACK=%b want 0 0 1111", HRQ, GrantValid, DACK); end
      checks++; if (SwReqClr !== 4'b0100) begin
         errors++; $display("FAIL basic_clr: got %b want 0100", SwReqClr); end
   endtask

   task automatic test_priority();
      int ch;
      int exp_rot [3] = '{1, 3, 1};
      CommandReg = 8'h00;
      do_reset();
      DREQ = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         serve(ch);
         checks++; if (ch != 1) begin
            errors++; $display("FAIL prio_fixed[%0d]: got %0d want 1", i, ch); end
      end
      CommandReg = 8'h10;
      do_reset();
      DREQ = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         serve(ch);
         checks++; if (ch != exp_rot[i]) begin
            errors++; $display("FAIL prio_rot[%0d]: got %0d want %0d", i, ch, exp_rot[i]); end
      end
   endtask

   task automatic test_mask_swreq();
      int ch;
      bit seen = 1'b0;
      CommandReg = 8'h00;
      do_reset();
      MaskReg = 4'b0001; DREQ = 4'b0001;
      repeat (6) begin @(negedge Clock); seen |= (HRQ === 1'b1); end
      checks++; if (seen || PendingReq !== 4'h0) begin
         errors++; $display("FAIL mask_block: HRQ_seen=%b PEND=%b want 0 0000", seen, PendingReq); end
      SwReq = 4'b0001;
      serve(ch);
      checks++; if (ch != 0) begin
         errors++; $display("FAIL sw_grant: got %0d want 0", ch); end
      checks++; if (SwReqClr !== 4'b0001) begin
         errors++; $display("FAIL sw_clr: got %b want 0001", SwReqClr); end
      SwReq = '0;
      @(negedge Clock);
      checks++; if (SwReqClr !== 4'b0000) begin
         errors++; $display("FAIL sw_clr_pulse: got %b want 0000", SwReqClr); end
   endtask

   task automatic test_disable();
      bit seen = 1'b0;
      bit ok;
      CommandReg = 8'h04;
      do_reset();
      DREQ = 4'hF;
      repeat (10) begin @(negedge Clock); seen |= (HRQ === 1'b1); end
      checks++; if (seen) begin
         errors++; $display("FAIL dis_idle: HRQ rose, want stays 0"); end
      CommandReg = 8'h00;
      wait_hrq(ok);
      checks++; if (!ok) begin
         errors++; $display("FAIL dis_enable: HRQ timeout, want 1"); end
      HLDA = 1'b1;
      @(negedge Clock);
      CommandReg = 8'h04;
      repeat (2) @(negedge Clock);
      checks++; if (GrantValid !== 1'b1 || HRQ !== 1'b1 || GrantChan !== 2'd0) begin
         errors++; $display("FAIL dis_in_grant: GV=%b HRQ=%b CH=%0d want 1 1 0", GrantValid, HRQ, GrantChan); end
      ServiceDone = 1'b1;
      @(negedge Clock);
      ServiceDone = 1'b0; HLDA = 1'b0;
      seen = (HRQ === 1'b1);
      repeat (10) begin @(negedge Clock); seen |= (HRQ === 1'b1); end
      checks++; if (seen) begin
         errors++; $display("FAIL dis_after: HRQ rose after service, want 0"); end
      CommandReg = 8'h00;
   endtask

   task automatic test_abort();
      int ch;
      bit ok;
      CommandReg = 8'h10;
      do_reset();
      DREQ = 4'b0010;
      serve(ch);                            // pointer moves to ch1
      checks++; if (ch != 1) begin
         errors++; $display("FAIL abort_pre: got %0d want 1", ch); end
      DREQ = 4'b1000;
      wait_hrq(ok);
      repeat (3) @(negedge Clock);
      HLDA = 1'b1;
      @(negedge Clock);
      checks++; if (!ok || GrantValid !== 1'b1 || GrantChan !== 2'd3) begin
         errors++; $display("FAIL abort_grant: GV=%b CH=%0d want 1 3", GrantValid, GrantChan); end
      HLDA = 1'b0; DREQ = 4'b1001;
      @(negedge Clock);
      checks++; if (GrantValid !== 1'b0 || HRQ !== 1'b0 || DACK !== 4'hF || SwReqClr !== 4'h0) begin
         errors++; $display("FAIL abort_idle: GV=%b HRQ=%b DACK=%b CLR=%b want 0 0 1111 0000",
                            GrantValid, HRQ, DACK, SwReqClr); end
      // pointer still at ch1: ch3 outranks ch0 (after an update it would be ch0)
      serve(ch);
      checks++; if (ch != 3) begin
         errors++; $display("FAIL abort_ptr: got %0d want 3", ch); end
   endtask

   task automatic test_withdraw_reset();
      bit ok;
      CommandReg = 8'h00;
      do_reset();
      SwReq = 4'b0100;
      wait_hrq(ok);
      SwReq = '0;
      @(negedge Clock);
      checks++; if (!ok || HRQ !== 1'b0) begin
         errors++; $display("FAIL withdraw: HRQ=%b ok=%b want 0 1", HRQ, ok); end
      SwReq = 4'b0010;
      wait_hrq(ok);
      HLDA = 1'b1;
      @(negedge Clock);
      checks++; if (!ok || GrantValid !== 1'b1 || GrantChan !== 2'd1) begin
         errors++; $display("FAIL rst_pre: GV=%b CH=%0d want 1 1", GrantValid, GrantChan); end
      Reset = 1'b1;
      @(negedge Clock);
      checks++; if (HRQ !== 1'b0 || GrantValid !== 1'b0 || GrantChan !== 2'd0 || PendingReq !== 4'h0 ||
                    SwReqClr !== 4'h0 || DACK !== 4'hF) begin
         errors++; $display("FAIL rst_grant: HRQ=%b GV=%b CH=%0d PEND=%b CLR=%b DACK=%b want all reset",
                            HRQ, GrantValid, GrantChan, PendingReq, SwReqClr, DACK); end
      Reset = 1'b0; SwReq = '0; HLDA = 1'b0;
   endtask

   task automatic test_random();
      logic [NCH-1:0] exp_dack;
      logic [7:0]     r;
      CommandReg = 8'h00;
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge Clock);
         exp_dack = {NCH{~CommandReg[7]}};
         if (m_phase == 2) exp_dack[m_chan] = CommandReg[7];
         checks++;
         if (HRQ !== (m_phase != 0) || GrantValid !== (m_phase == 2) || GrantChan !== 2'(m_chan) ||
             PendingReq !== m_pendreg || SwReqClr !== m_clr || DACK !== exp_dack) begin
            errors++;
            $display("FAIL random cyc %0d: HRQ %b/%b GV %b/%b CH %0d/%0d PEND %b/%b CLR %b/%b DACK %b/%b (got/exp)",
                     cyc, HRQ, (m_phase != 0), GrantValid, (m_phase == 2), GrantChan, m_chan,
                     PendingReq, m_pendreg, SwReqClr, m_clr, DACK, exp_dack);
         end
         if ($urandom_range(0, 24) == 0) begin
            r = 8'($urandom);
            r[2] = r[2] & ($urandom_range(0, 2) == 0);
            CommandReg = r;
         end
         if ($urandom_range(0, 3) == 0) DREQ = 4'($urandom);
         if ($urandom_range(0, 5) == 0) MaskReg = 4'($urandom);
         if ($urandom_range(0, 5) == 0) SwReq = 4'($urandom) & 4'($urandom);
         HLDA = HRQ ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 7) == 0);
         ServiceDone = ($urandom_range(0, 4) == 0);
         Reset = ($urandom_range(0, 99) == 0);
      end
      Reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_priority();
      test_mask_swreq();
      test_disable();
      test_abort();
      test_withdraw_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
